// File: rtl/crc_pkg.sv
// crc_pkg: shared types and constants for the CRC byte sequencer.
// Holds the sequencer state encoding and the byte/bit-index widths.
package crc_pkg;

  localparam int BYTE_BITS = 8;
  localparam int BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT,
    SHIFT,
    CAPTURE,
    RESULT
  } state_t;

endpackage

// File: rtl/crc_byte_sequencer_if.sv
// crc_byte_sequencer_if: byte stream in, held CRC result out.
// master drives bytes and consumes results; slave is the sequencer.
interface crc_byte_sequencer_if #(
  parameter int MAX_BITS = 32
);
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [MAX_BITS-1:0] out_crc;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_crc
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_crc
  );
endinterface

// File: rtl/crc_byte_sequencer.sv
// crc_byte_sequencer: byte-stream front end for the bit-serial crcN engine.
// Define CRC_SEQ_PREFETCH_EN for a one-byte holder that removes WAIT gaps.
module crc_byte_sequencer
  import crc_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  crc_byte_sequencer_if.slave  bus,
  output logic                 crc_initialize,
  output logic                 crc_shift,
  output logic [BYTE_BITS-1:0] crc_data,
  output logic [BIT_IDX_W-1:0] crc_bit_index,
  input  logic [MAX_BITS-1:0]  crc_value,
  output logic [COUNT_W-1:0]   byte_count,
  output logic                 busy
);

  state_t               state;
  logic [BIT_IDX_W-1:0] bit_cnt;
  logic [BYTE_BITS-1:0] cur_data;
  logic                 cur_last;
  logic [MAX_BITS-1:0]  crc_q;

  logic in_hs;
  logic restart;
  logic accept;
  logic last_bit;

  assign in_hs    = bus.in_valid & bus.in_ready;
  assign restart  = start & ((state == IDLE) | (state == WAIT));
  assign accept   = in_hs & ~restart;
  assign last_bit = (state == SHIFT) & (bit_cnt == '0);

`ifdef CRC_SEQ_PREFETCH_EN
  logic                 hold_full;
  logic                 hold_last;
  logic [BYTE_BITS-1:0] hold_data;

  assign bus.in_ready = (state == WAIT)
                      | ((state == SHIFT) & ~hold_full & ~cur_last);

  // Bytes taken at the final bit bypass the holder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      hold_data <= '0;
    end else if (restart) begin
      hold_full <= 1'b0;
    end else if (accept & (state == SHIFT) & ~last_bit) begin
      hold_full <= 1'b1;
      hold_data <= bus.in_data;
      hold_last <= bus.in_last;
    end else if (last_bit) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign bus.in_ready = (state == WAIT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      cur_data <= '0;
      cur_last <= 1'b0;
      crc_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= INIT;
        end
        INIT: begin
          state <= WAIT;
        end
        WAIT: begin
          if (start) begin
            state <= INIT;
          end else if (accept) begin
            cur_data <= bus.in_data;
            cur_last <= bus.in_last;
            bit_cnt  <= '1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            if (cur_last) begin
              state <= CAPTURE;
`ifdef CRC_SEQ_PREFETCH_EN
            end else if (hold_full) begin
              cur_data <= hold_data;
              cur_last <= hold_last;
            end else if (accept) begin
              cur_data <= bus.in_data;
              cur_last <= bus.in_last;
`endif
            end else begin
              state <= WAIT;
            end
          end
        end
        CAPTURE: begin
          crc_q <= crc_value;
          state <= RESULT;
        end
        RESULT: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count <= '0;
    end else if (restart) begin
      byte_count <= '0;
    end else if (accept & ~&byte_count) begin
      byte_count <= byte_count + 1'b1;
    end
  end

  assign crc_initialize = (state == INIT);
  assign crc_shift      = (state == SHIFT);
  assign crc_bit_index  = crc_shift ? bit_cnt : '0;
  assign crc_data       = cur_data;
  assign bus.out_valid  = (state == RESULT);
  assign bus.out_crc    = crc_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_crc_byte_sequencer.sv
// tb_crc_byte_sequencer: directed scoreboard bench for crc_byte_sequencer.
// A small bit-serial CRC engine model stands in for crcN.
module tb_crc_byte_sequencer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] crc;
    logic [15:0] cnt;
  } exp_t;

`ifdef CRC_SEQ_PREFETCH_EN
  localparam int LAT2 = 20;
  localparam int LAT9 = 76;
`else
  localparam int LAT2 = 21;
  localparam int LAT9 = 84;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        crc_initialize;
  logic        crc_shift;
  logic [7:0]  crc_data;
  logic [2:0]  crc_bit_index;
  logic [31:0] crc_value;
  logic [15:0] byte_count;
  logic        busy;

  crc_byte_sequencer_if #(.MAX_BITS(32)) bus();

  crc_byte_sequencer #(
    .MAX_BITS(32),
    .COUNT_W (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bus           (bus.slave),
    .crc_initialize(crc_initialize),
    .crc_shift     (crc_shift),
    .crc_data      (crc_data),
    .crc_bit_index (crc_bit_index),
    .crc_value     (crc_value),
    .byte_count    (byte_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   init_rel = -1;
  bit   overlap = 1'b0;
  int   sh_cyc[$];
  int   sh_idx[$];
  exp_t sb[$];

  int          cw = 8;
  logic [31:0] cpoly = 32'h07;
  logic [31:0] cinit = 32'h0;
  logic [31:0] cxor = 32'h0;
  bit          crefin = 1'b0;
  bit          crefout = 1'b0;
  logic [31:0] eng = 32'h0;

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] eng_step(input logic [31:0] c,
                                           input logic b, input int w,
                                           input logic [31:0] p);
    logic fb;
    fb = c[w-1] ^ b;
    c = (c << 1) & wmask(w);
    if (fb) c = c ^ p;
    return c;
  endfunction

  function automatic logic [31:0] eng_out(input logic [31:0] c,
                                          input int w, input bit ro,
                                          input logic [31:0] x);
    logic [31:0] r;
    r = c;
    if (ro) begin
      r = '0;
      for (int i = 0; i < 32; i++)
        if (i < w) r[i] = c[w-1-i];
    end
    return (r ^ x) & wmask(w);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crc_initialize)
      eng <= cinit;
    else if (crc_shift)
      eng <= eng_step(eng,
                      crefin ? crc_data[3'd7 - crc_bit_index]
                             : crc_data[crc_bit_index],
                      cw, cpoly);
  end

  assign crc_value = eng_out(eng, cw, crefout, cxor);

  always @(negedge clk) begin
    if (crc_initialize && crc_shift) overlap = 1'b1;
    if (crc_initialize) init_rel = cyc - t0;
    if (crc_shift) begin
      sh_cyc.push_back(cyc - t0);
      sh_idx.push_back(int'(crc_bit_index));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".in_ready"}, bus.in_ready, 0);
    chk({tag, ".crc_initialize"}, crc_initialize, 0);
    chk({tag, ".crc_shift"}, crc_shift, 0);
    chk({tag, ".crc_data"}, crc_data, 0);
    chk({tag, ".crc_bit_index"}, crc_bit_index, 0);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".out_crc"}, bus.out_crc, 0);
    chk({tag, ".byte_count"}, byte_count, 0);
    chk({tag, ".busy"}, busy, 0);
  endtask

  task automatic cfg(input int w, input logic [31:0] p,
                     input logic [31:0] i, input bit ri, input bit ro,
                     input logic [31:0] x);
    cw = w; cpoly = p; cinit = i; crefin = ri; crefout = ro; cxor = x;
  endtask

  function automatic bq_t digits(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(8'h31 + i));
    return q;
  endfunction

  task automatic send_bytes(input bq_t b, input bit lastflag, input bit rnd);
    int g;
    bit hs;
    foreach (b[i]) begin
      g = 0;
      hs = 1'b0;
      bus.in_data = b[i];
      bus.in_last = lastflag && (i == b.size() - 1);
      while (!hs && g < 500) begin
        bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        hs = bus.in_valid && bus.in_ready;
        @(negedge clk);
        g++;
      end
      chk("send_handshake", hs, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic wait_result(input int lat);
    int g;
    exp_t e;
    g = 0;
    while (!bus.out_valid && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("out_valid_seen", bus.out_valid, 1);
    if (lat >= 0) chk("latency", cyc - t0, lat);
    chk("sb_level", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_crc", bus.out_crc, e.crc);
      chk("byte_count", byte_count, e.cnt);
    end
  endtask

  task automatic run_msg(input bq_t b, input bit rnd,
                         input logic [31:0] ecrc, input int lat);
    exp_t e;
    e.crc = ecrc;
    e.cnt = 16'(b.size());
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    init_rel = -1;
    sh_cyc.delete();
    sh_idx.delete();
    @(negedge clk);
    start = 1'b0;
    send_bytes(b, 1'b1, rnd);
    wait_result(lat);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("busy_after_ready", busy, 0);
    chk("valid_after_ready", bus.out_valid, 0);
  endtask

  initial begin
    bq_t  q;
    exp_t e;
    int   g;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    cfg(8, 32'h07, 32'h0, 1'b0, 1'b0, 32'h0);
    q = {8'h00};
    run_msg(q, 1'b0, 32'h00, 12);
    chk("init_cycle", init_rel, 1);
    chk("shift_count", sh_cyc.size(), 8);
    for (int k = 0; k < 8 && k < sh_cyc.size(); k++) begin
      chk("shift_cycle", sh_cyc[k], 3 + k);
      chk("shift_index", sh_idx[k], 7 - k);
    end
    release_result();

    q = {8'h00, 8'h00};
    run_msg(q, 1'b0, 32'h00, LAT2);
    release_result();

    run_msg(digits(9), 1'b0, 32'hF4, LAT9);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_crc", bus.out_crc, 32'hF4);
      chk("stall_no_init", crc_initialize, 0);
    end
    start = 1'b0;
    release_result();

    cfg(32, 32'h04C11DB7, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_msg(digits(9), 1'b1, 32'hCBF4_3926, -1);
    release_result();

    cfg(16, 32'h1021, 32'hFFFF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bytes(digits(2), 1'b0, 1'b0);
    g = 0;
    while (!(bus.in_ready && !crc_shift) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("abort_wait_reached", bus.in_ready && !crc_shift, 1);
    chk("abort_count_before", byte_count, 2);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_count_cleared", byte_count, 0);
    chk("abort_reinit", crc_initialize, 1);
    e.crc = 32'h29B1;
    e.cnt = 16'd9;
    sb.push_back(e);
    send_bytes(digits(9), 1'b1, 1'b0);
    wait_result(-1);
    release_result();

    cfg(8, 32'h07, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    bus.in_last = 1'b0;
    g = 0;
    while (!crc_shift && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.in_valid = 1'b0;
    chk("midshift_reached", crc_shift, 1);
    #2 rst = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst = 1'b1;
    run_msg(digits(9), 1'b0, 32'hF4, LAT9);
    release_result();

    chk("init_shift_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_byte_sequencer.md
Name: crc_byte_sequencer

Overview:
- Byte-stream front end for the bit-serial crcN engine.
- Accepts message bytes over a valid/ready handshake and pulses the engine's initialize at message start.
- Drives shift, data and bit_index for 8 cycles per byte.
- Captures the final CRC into a held result register with its own valid/ready handshake.
- CRC configuration (poly, width, reflect, xor) is wired to crcN directly; this block only sequences.

Parameters:
MAX_BITS, 32, width of the crc word from the engine.
COUNT_W, 16, width of the per-message byte counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (rst=0 resets)
start  input  1  begin new message; honored in IDLE and WAIT only
in_valid  input  1  byte available
in_data  input  8  message byte
in_last  input  1  qualifies the final byte of the message
in_ready  output  1  byte accepted when in_valid & in_ready
crc_initialize  output  1  to crcN initialize
crc_shift  output  1  to crcN shift
crc_data  output  8  to crcN data (held byte)
crc_bit_index  output  3  to crcN bit_index
crc_value  input  MAX_BITS  from crcN crc
out_valid  output  1  result held
out_ready  input  1  result consumed
out_crc  output  MAX_BITS  registered result
byte_count  output  COUNT_W  bytes accepted in current/last message, saturating
busy  output  1  state != IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; all outputs 0; out_crc=0, byte_count=0, data/last regs=0.
- IDLE: start=1 -> INIT; byte_count cleared.
- INIT (1 cycle): crc_initialize=1 -> WAIT.
- WAIT: in_ready=1.
  - start=1 has priority: -> INIT, byte_count cleared, input byte not accepted.
  - Else on handshake: latch in_data/in_last, byte_count+1 (saturate at all-ones), -> SHIFT with bit counter=7.
- SHIFT (8 cycles): crc_shift=1; crc_bit_index = counter, counting 7 down to 0; crc_data = held byte.
  - At counter=0: last held -> CAPTURE; else -> WAIT.
  - start ignored.
- CAPTURE (1 cycle): out_crc <= crc_value (engine updated by final shift edge) -> RESULT.
- RESULT: out_valid=1, out_crc stable. out_ready=1 -> IDLE (out_valid low next cycle). start ignored while in RESULT.
- crc_initialize and crc_shift are never high together.
- in_ready is low outside WAIT (base build).
- Latency, base build: start sampled at cycle 0, bytes presented continuously -> out_valid first high at cycle 3 + 9N for an N-byte message.
- Output ready timing: out_ready high on the same cycle out_valid rises completes in one cycle.

Optional Feature:
CRC_SEQ_PREFETCH_EN
- Defined:
  - A one-entry holding register (byte+last) is added.
  - in_ready is also high during SHIFT when the holder is empty and the current byte is not last.
  - At counter=0 with the holder full: move the holder into the shift byte and go directly to SHIFT (counter=7) with no WAIT cycle.
  - byte_count increments at acceptance into the holder.
  - Continuous input -> out_valid at cycle 3 + 9 + 8(N-1).
  - start in WAIT also clears the holder.
- Undefined: behaviour and timing exactly as the base description.

Decomposition:
- Shared package crc_pkg:
  - state enum (IDLE, INIT, WAIT, SHIFT, CAPTURE, RESULT);
  - BYTE_BITS=8 and BIT_IDX_W=3 constants.
- No sub-module; the FSM plus the counter fits in one module. The bench instantiates crcN alongside the sequencer.

Test Plan:
- CRC-8 (poly 0x07, init 0, no reflect, xor 0), bytes "123456789" with last on '9' -> out_crc=0xF4, byte_count=9.
- CRC-32 (0x04C11DB7, init/xor 0xFFFFFFFF, reflect in/out), same string -> out_crc=0xCBF43926. With in_valid toggled randomly, result unchanged.
- Single byte 0x00 (last), start at cycle 0, in_valid held -> crc_initialize at cycle 1, shift cycles 3-10 with bit_index 7..0, out_valid at cycle 12 (base). With prefetch, 2 bytes -> out_valid at cycle 20.
- out_ready held low 5 cycles -> out_valid and out_crc stable. Pulsing start during RESULT is ignored. out_ready=1 -> busy low next cycle.
- Abort: CRC-16/CCITT-FALSE (0x1021, init 0xFFFF).
  - "12" accepted, then start asserted in WAIT -> re-initialize, byte_count=0.
  - Then "123456789" -> 0x29B1.
- Reset asserted mid-SHIFT -> all outputs 0 immediately (async). After release, start + "123456789" CRC-8 -> 0xF4.
